// File: rtl/io_read_port_ctrl.sv
// Processor read path for the UART SoC: port mux, sticky RX/TX/overrun flags
// with clear-on-read, interrupt mask and a request/acknowledge handshake.
module io_read_port_ctrl #(
   parameter int         DATA_W    = 8,
   parameter logic [3:0] RX_PORT   = 4'h0,
   parameter logic [3:0] STAT_PORT = 4'h1,
   parameter logic [3:0] MASK_PORT = 4'h2
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [3:0]        PORT_ID,
   input  logic              READ_STROBE,
   input  logic              WRITE_STROBE,
   input  logic [15:0]       OUT_PORT,
   input  logic [DATA_W-1:0] RX_DATA,
   input  logic              RX_RDY,
   input  logic              TX_RDY,
   input  logic              INTERRUPT_ACK,
   output logic [15:0]       IN_PORT,
   output logic              INTERRUPT
);

   typedef enum logic {IDLE, REQ} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [DATA_W-1:0] rx_hold;
   logic              rxf;
   logic              txf;
   logic              ovf;
   logic              en_rx;
   logic              en_tx;
   logic              tx_rdy_q;
   logic              rd_rx;
   logic              rd_stat;
   logic              wr_mask;
   logic              tx_rise;
   logic              ev;

   assign rd_rx   = READ_STROBE && (PORT_ID == RX_PORT);
   assign rd_stat = READ_STROBE && (PORT_ID == STAT_PORT);
   assign wr_mask = WRITE_STROBE && (PORT_ID == MASK_PORT);
   assign tx_rise = TX_RDY && !tx_rdy_q;
   assign ev      = (RX_RDY && en_rx) || (tx_rise && en_tx);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         rx_hold  <= '0;
         rxf      <= 1'b0;
         txf      <= 1'b0;
         ovf      <= 1'b0;
         en_rx    <= 1'b0;
         en_tx    <= 1'b0;
         tx_rdy_q <= 1'b1;
      end else begin
         tx_rdy_q <= TX_RDY;
         // Every flag: a set in the same cycle as its clearing read wins.
         if (RX_RDY) begin
            rx_hold <= RX_DATA;
            rxf     <= 1'b1;
         end else if (rd_rx) begin
            rxf <= 1'b0;
         end
         if (RX_RDY && rxf && !rd_rx) begin
            ovf <= 1'b1;
         end else if (rd_stat) begin
            ovf <= 1'b0;
         end
         if (tx_rise) begin
            txf <= 1'b1;
         end else if (rd_stat) begin
            txf <= 1'b0;
         end
         if (wr_mask) begin
            en_tx <= OUT_PORT[1];
            en_rx <= OUT_PORT[0];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Events arriving while a request is pending merge into it.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (ev) begin
               state_nxt = REQ;
            end
         end
         REQ: begin
            if (INTERRUPT_ACK && !ev) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign INTERRUPT = (state == REQ);

   always_comb begin
      IN_PORT = 16'h0000;
      if (PORT_ID == RX_PORT) begin
         IN_PORT[DATA_W-1:0] = rx_hold;
      end else if (PORT_ID == STAT_PORT) begin
         IN_PORT[2:0] = {ovf, txf, rxf};
      end else if (PORT_ID == MASK_PORT) begin
         IN_PORT[1:0] = {en_tx, en_rx};
      end
   end

endmodule

// File: tb/tb_io_read_port_ctrl.sv
// Scoreboard bench for io_read_port_ctrl: stimulus queues expected values,
// a negedge monitor pops and compares on every read or interrupt probe.
module tb_io_read_port_ctrl;

   localparam logic [3:0] RXP = 4'h0;
   localparam logic [3:0] STP = 4'h1;
   localparam logic [3:0] MKP = 4'h2;

   typedef struct {
      string       name;
      bit          irq;
      logic [15:0] val;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  port_id;
   logic        read_strobe;
   logic        write_strobe;
   logic [15:0] out_port;
   logic [7:0]  rx_data;
   logic        rx_rdy;
   logic        tx_rdy;
   logic        interrupt_ack;
   logic [15:0] in_port;
   logic        interrupt;
   logic        probe;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   io_read_port_ctrl dut (
      .CLK          (clk),
      .RESET        (reset),
      .PORT_ID      (port_id),
      .READ_STROBE  (read_strobe),
      .WRITE_STROBE (write_strobe),
      .OUT_PORT     (out_port),
      .RX_DATA      (rx_data),
      .RX_RDY       (rx_rdy),
      .TX_RDY       (tx_rdy),
      .INTERRUPT_ACK(interrupt_ack),
      .IN_PORT      (in_port),
      .INTERRUPT    (interrupt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (read_strobe || probe) begin
         exp_t e;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: no expected entry queued");
         end else begin
            logic [15:0] act;
            e = q.pop_front();
            checks++;
            act = e.irq ? {15'b0, interrupt} : in_port;
            if (act !== e.val) begin
               errors++;
               $display("FAIL %s: got %h, expected %h", e.name, act, e.val);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      read_strobe   = 1'b0;
      write_strobe  = 1'b0;
      rx_rdy        = 1'b0;
      interrupt_ack = 1'b0;
      probe         = 1'b0;
   endtask

   task automatic push(input string n, input bit irq, input logic [15:0] v);
      exp_t e;
      e.name = n;
      e.irq  = irq;
      e.val  = v;
      q.push_back(e);
   endtask

   task automatic rd(input logic [3:0] p, input logic [15:0] v, input string n);
      port_id     = p;
      read_strobe = 1'b1;
      push(n, 1'b0, v);
      step();
   endtask

   task automatic rx(input logic [7:0] d);
      rx_data = d;
      rx_rdy  = 1'b1;
      step();
   endtask

   task automatic wr_mask(input logic [1:0] m);
      port_id      = MKP;
      out_port     = {14'b0, m};
      write_strobe = 1'b1;
      step();
   endtask

   task automatic irq_chk(input logic v, input string n);
      probe = 1'b1;
      push(n, 1'b1, {15'b0, v});
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      port_id = RXP;
      read_strobe = 1'b0;
      write_strobe = 1'b0;
      out_port = 16'h0;
      rx_data = 8'h0;
      rx_rdy = 1'b0;
      tx_rdy = 1'b1;
      interrupt_ack = 1'b0;
      probe = 1'b0;
      step();
      step();
      reset = 1'b0;
      rd(RXP, 16'h0000, "reset_rx");
      rd(STP, 16'h0000, "reset_stat");
      rd(MKP, 16'h0000, "reset_mask");
      irq_chk(1'b0, "reset_irq");

      // 1: single byte
      rx(8'hA5);
      rd(STP, 16'h0001, "t1_stat_rxf");
      rd(RXP, 16'h00A5, "t1_rx_data");
      rd(STP, 16'h0000, "t1_stat_clear");

      // 2: overrun
      rx(8'h11);
      rx(8'h22);
      rd(STP, 16'h0005, "t2_stat_ovf");
      rd(RXP, 16'h0022, "t2_rx_data");
      rd(STP, 16'h0000, "t2_stat_clear");

      // 3: capture during RX read
      rx(8'h11);
      rx_data = 8'h33;
      rx_rdy = 1'b1;
      port_id = RXP;
      read_strobe = 1'b1;
      push("t3_rx_old", 1'b0, 16'h0011);
      step();
      rd(STP, 16'h0001, "t3_stat_rxf_kept");
      rd(RXP, 16'h0033, "t3_rx_new");
      rd(STP, 16'h0000, "t3_stat_clear");

      // 4: RX interrupt
      wr_mask(2'b01);
      rd(MKP, 16'h0001, "t4_mask");
      irq_chk(1'b0, "t4_irq_idle");
      rx(8'h44);
      irq_chk(1'b1, "t4_irq_set");
      rx(8'h55);
      irq_chk(1'b1, "t4_irq_held");
      interrupt_ack = 1'b1;
      step();
      irq_chk(1'b0, "t4_irq_acked");
      rd(STP, 16'h0005, "t4_stat");
      rd(RXP, 16'h0055, "t4_rx");
      rd(STP, 16'h0000, "t4_stat_clear");
      wr_mask(2'b00);
      rx(8'h66);
      irq_chk(1'b0, "t4_masked_irq");
      rd(RXP, 16'h0066, "t4_masked_rx");

      // 5: TX interrupt, ack collides with new event
      wr_mask(2'b10);
      tx_rdy = 1'b0;
      step();
      tx_rdy = 1'b1;
      step();
      irq_chk(1'b1, "t5_irq_tx");
      rd(STP, 16'h0002, "t5_stat_txf");
      tx_rdy = 1'b0;
      step();
      tx_rdy = 1'b1;
      interrupt_ack = 1'b1;
      step();
      irq_chk(1'b1, "t5_irq_ack_ev");
      rd(STP, 16'h0002, "t5_stat_txf2");
      interrupt_ack = 1'b1;
      step();
      irq_chk(1'b0, "t5_irq_acked");
      interrupt_ack = 1'b1;
      step();
      irq_chk(1'b0, "t5_ack_idle");
      rd(STP, 16'h0000, "t5_stat_clear");

      // 6: reset mid-operation
      wr_mask(2'b01);
      rx(8'h77);
      irq_chk(1'b1, "t6_irq_pre");
      rd(STP, 16'h0001, "t6_stat_pre");
      reset = 1'b1;
      rx_data = 8'h99;
      rx_rdy = 1'b1;
      step();
      reset = 1'b0;
      irq_chk(1'b0, "t6_irq");
      rd(RXP, 16'h0000, "t6_rx");
      rd(STP, 16'h0000, "t6_stat");
      rd(MKP, 16'h0000, "t6_mask");
      rd(4'h7, 16'h0000, "t6_unmapped");
      step();

      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d left, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
